// File: rtl/load_store_unit.sv
// Load/store unit: stalls the core, runs one word-aligned bus access with lane steering and extension.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned H/W accesses instead of issuing them).
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        BusErr,
  output logic        Fault
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  localparam logic [1:0]  SZ_B = 2'd0;
  localparam logic [1:0]  SZ_H = 2'd1;
  localparam logic [1:0]  SZ_W = 2'd2;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        buserr_q, buserr_d;

  logic        req;
  logic [1:0]  size_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  assign req = MemRead | MemWrite;

  // Unlisted Funct3 encodings fall through to word size.
  always_comb begin
    size_in = SZ_W;
    if (Funct3 == 3'b000 || Funct3 == 3'b100) size_in = SZ_B;
    else if (Funct3 == 3'b001 || Funct3 == 3'b101) size_in = SZ_H;
  end

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = Mem_WrData;
    if (size_in == SZ_B) begin
      be_in    = 4'b0001 << Mem_WrAddr[1:0];
      wdata_in = {4{Mem_WrData[7:0]}};
    end else if (size_in == SZ_H) begin
      be_in    = Mem_WrAddr[1] ? 4'b1100 : 4'b0011;
      wdata_in = {2{Mem_WrData[15:0]}};
    end
  end

  always_comb begin
    load_byte = bus_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    load_byte = bus_rdata[15:8];
      2'd2:    load_byte = bus_rdata[23:16];
      2'd3:    load_byte = bus_rdata[31:24];
      default: load_byte = bus_rdata[7:0];
    endcase
    load_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    load_ext  = bus_rdata;
    if (size_q == SZ_B)
      load_ext = uns_q ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
    else if (size_q == SZ_H)
      load_ext = uns_q ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  logic fault_q, fault_d;
  assign misaligned = ((size_in == SZ_H) && Mem_WrAddr[0]) ||
                      ((size_in == SZ_W) && (Mem_WrAddr[1:0] != 2'b00));
  assign Fault = fault_q;
`else
  assign Fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      size_q   <= SZ_W;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      buserr_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q  <= fault_d;
`endif
    end
  end

  // Error flags are only ever set on the transition into DONE, so they pulse for exactly one cycle.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    uns_d    = uns_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    buserr_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    fault_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) begin
          addr_d  = Mem_WrAddr;
          size_d  = size_in;
          uns_d   = Funct3[2];
          wdata_d = wdata_in;
          be_d    = be_in;
          we_d    = MemWrite;
          state_d = BUS;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned) begin
            state_d = DONE;
            fault_d = 1'b1;
            rdata_d = '0;
          end
`endif
        end
      end
      BUS: begin
        if (bus_ack) begin
          rdata_d = load_ext;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d  = '0;
          buserr_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_req   = (state_q == BUS);
    bus_we    = bus_req & we_q;
    bus_be    = bus_req ? be_q : 4'b0000;
    bus_addr  = {addr_q[31:2], 2'b00};
    bus_wdata = wdata_q;
    Stall     = ((state_q == IDLE) && req) || (state_q == BUS);
    ReadData  = rdata_q;
    BusErr    = buserr_q;
  end

endmodule
